// File: rtl/buzz_arbiter.sv
// Fixed-priority, preemptive owner arbiter for the shared Buzz tone generator.
// Every ownership change is separated by a silent gap of GAP_CYCLES cycles.
module buzz_arbiter #(
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned FW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [FW-1:0] freq0,
    input  logic [FW-1:0] freq1,
    input  logic [FW-1:0] freq2,
    input  logic          mode_lock,
    output logic [2:0]    grant,
    output logic [FW-1:0] frequency,
    output logic          busy,
    output logic          switch_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [31:0]   gap_cnt_q, gap_cnt_d;
    logic [2:0]    grant_q, grant_d;
    logic [FW-1:0] freq_q, freq_d;
    logic          busy_q, busy_d;
    logic          pulse_q, pulse_d;

    logic          req_any;
    logic [1:0]    pick;
    logic          owner_req;
    logic          higher_req;
    logic [FW-1:0] owner_freq;

    assign req_any = |req;

    always_comb begin
        pick = 2'd2;
        if (req[0]) begin
            pick = 2'd0;
        end else if (req[1]) begin
            pick = 2'd1;
        end
    end

    // Per-owner views of the request lines and the frequency words.
    always_comb begin
        owner_req  = 1'b0;
        higher_req = 1'b0;
        owner_freq = '0;
        case (owner_q)
            2'd0: begin
                owner_req  = req[0];
                owner_freq = freq0;
            end
            2'd1: begin
                owner_req  = req[1];
                higher_req = req[0];
                owner_freq = freq1;
            end
            2'd2: begin
                owner_req  = req[2];
                higher_req = |req[1:0];
                owner_freq = freq2;
            end
            default: begin
                owner_req  = 1'b0;
                higher_req = 1'b0;
                owner_freq = '0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gap_cnt_d = gap_cnt_q;
        freq_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_OWN;
                    owner_d = pick;
                end
            end
            S_OWN: begin
                // Release and preemption both lead to the same gap entry.
                if (!owner_req || (higher_req && !mode_lock)) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_CYCLES - 32'd1;
                end else begin
                    freq_d = owner_freq;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 32'd0) begin
                    if (req_any) begin
                        state_d = S_OWN;
                        owner_d = pick;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        grant_d = (state_d == S_OWN) ? (3'b001 << owner_d) : 3'b000;
        pulse_d = (state_d == S_OWN) && (state_q != S_OWN);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 2'd0;
            gap_cnt_q <= 32'd0;
            grant_q   <= 3'b000;
            freq_q    <= '0;
            busy_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            gap_cnt_q <= gap_cnt_d;
            grant_q   <= grant_d;
            freq_q    <= freq_d;
            busy_q    <= busy_d;
            pulse_q   <= pulse_d;
        end
    end

    assign grant        = grant_q;
    assign frequency    = freq_q;
    assign busy         = busy_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Bench for buzz_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level owner/gap reference model.
module tb_buzz_arbiter;

    localparam int G = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [31:0] freq0, freq1, freq2;
    logic        mode_lock;
    logic [2:0]  grant;
    logic [31:0] frequency;
    logic        busy;
    logic        switch_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current owner (-1 = nobody) and remaining silent cycles.
    int          m_own;
    int          m_gap;
    logic [2:0]  e_grant;
    logic [31:0] e_freq;
    logic        e_busy;
    logic        e_pulse;

    buzz_arbiter #(.GAP_CYCLES(G), .FW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .freq0        (freq0),
        .freq1        (freq1),
        .freq2        (freq2),
        .mode_lock    (mode_lock),
        .grant        (grant),
        .frequency    (frequency),
        .busy         (busy),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_gap   = 0;
        e_grant = 3'b000;
        e_freq  = 32'd0;
        e_busy  = 1'b0;
        e_pulse = 1'b0;
    endtask

    function automatic int req_pick(input logic [2:0] r);
        for (int i = 0; i < 3; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] freq_of(input int idx);
        if (idx == 0) return freq0;
        if (idx == 1) return freq1;
        return freq2;
    endfunction

    task automatic model_edge();
        int p;
        p       = req_pick(req);
        e_pulse = 1'b0;
        e_freq  = 32'd0;
        if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && p >= 0) begin
                m_own   = p;
                e_pulse = 1'b1;
            end
        end else if (m_own < 0) begin
            if (p >= 0) begin
                m_own   = p;
                e_pulse = 1'b1;
            end
        end else if (!req[m_own] || (!mode_lock && p < m_own)) begin
            m_own = -1;
            m_gap = G;
        end else begin
            e_freq = freq_of(m_own);
        end
        e_grant = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
        e_busy  = (m_own >= 0) || (m_gap > 0);
    endtask

    task automatic compare_all();
        check("grant", {29'd0, grant}, {29'd0, e_grant});
        check("frequency", frequency, e_freq);
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("switch_pulse", {31'd0, switch_pulse}, {31'd0, e_pulse});
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        #1;
        compare_all();
    endtask

    task automatic measure_gap(input string tag, input logic [2:0] exp_grant);
        int cnt;
        cnt = 0;
        step();
        while (grant == 3'b000 && cnt < 20) begin
            cnt++;
            step();
        end
        check({tag, "_len"}, cnt, G);
        check({tag, "_grant"}, {29'd0, grant}, {29'd0, exp_grant});
        check({tag, "_pulse"}, {31'd0, switch_pulse}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; req = 3'b111; mode_lock = 1'b0;
        freq0 = 32'd440; freq1 = 32'd330; freq2 = 32'd262;
        model_reset();

        // Reset held with all requests active, then released.
        repeat (3) step();
        check("rst_grant", {29'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();
        check("rel_grant", {29'd0, grant}, 32'd1);
        check("rel_pulse", {31'd0, switch_pulse}, 32'd1);
        step();
        check("rel_pulse_once", {31'd0, switch_pulse}, 32'd0);

        // Single owner with in-tenure frequency change.
        do_reset();
        req = 3'b100; freq2 = 32'd523;
        step();
        check("single_grant", {29'd0, grant}, 32'd4);
        step();
        check("single_freq", frequency, 32'd523);
        freq2 = 32'd587;
        step();
        check("single_freq_chg", frequency, 32'd587);

        // Preemption by free-play.
        req = 3'b101;
        measure_gap("preempt", 3'b001);
        step();
        check("preempt_freq", frequency, 32'd440);

        // mode_lock holds learn against free-play; release still honoured.
        do_reset();
        req = 3'b010;
        step();
        mode_lock = 1'b1; req = 3'b011;
        repeat (10) step();
        check("lock_hold", {29'd0, grant}, 32'd2);
        req = 3'b001;
        measure_gap("lock_rel", 3'b001);
        mode_lock = 1'b0;

        // Release to idle; a request toggled only mid-gap is ignored.
        req = 3'b000;
        step(); step();
        req = 3'b100;
        step();
        req = 3'b000;
        step(); step();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_grant", {29'd0, grant}, 32'd0);
        step();

        // Reset in the middle of a gap.
        req = 3'b010;
        step();
        req = 3'b000;
        step(); step();
        do_reset();
        req = 3'b010;
        step();
        check("rst_gap_grant", {29'd0, grant}, 32'd2);
        check("rst_gap_pulse", {31'd0, switch_pulse}, 32'd1);

        // Random traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(7) == 0) req[$urandom_range(2)] = ~req[$urandom_range(2)];
            if ($urandom_range(15) == 0) mode_lock = ~mode_lock;
            if ($urandom_range(3) == 0) freq0 = $urandom;
            if ($urandom_range(3) == 0) freq1 = $urandom;
            if ($urandom_range(3) == 0) freq2 = $urandom_range(4);
            if ($urandom_range(499) == 0) begin
                do_reset();
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
